// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with a DEPTH-entry output FIFO
// Defining DECODE_STAGE_RV32M_EN decodes the M-extension OP encodings; otherwise they are illegal.
module decode_stage #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic [1:0]      result_src,
    output logic            mem_write,
    output logic [2:0]      mem_width,
    output logic [4:0]      alu_control,
    output logic            alu_src,
    output logic [2:0]      immediate_control,
    output logic [2:0]      branch_type,
    output logic            is_branch,
    output logic            jump,
    output logic            pc_target_src,
    output logic            reg_write,
    output logic            illegal
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB  = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR  = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_OR  = 5'd8,  ALU_AND  = 5'd9, ALU_PASSB = 5'd10;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [1:0]      result_src;
        logic            mem_write;
        logic [2:0]      mem_width;
        logic [4:0]      alu_control;
        logic            alu_src;
        logic [2:0]      imm_ctrl;
        logic [2:0]      branch_type;
        logic            is_branch;
        logic            jump;
        logic            pc_target_src;
        logic            reg_write;
        logic            illegal;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    entry_t     w_dec;
    logic       w_legal;
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_push;
    logic       w_pop;

    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [4:0] a;
        a = ALU_ADD;
        case (f3)
            3'd0: a = alt ? ALU_SUB : ALU_ADD;
            3'd1: a = ALU_SLL;
            3'd2: a = ALU_SLT;
            3'd3: a = ALU_SLTU;
            3'd4: a = ALU_XOR;
            3'd5: a = alt ? ALU_SRA : ALU_SRL;
            3'd6: a = ALU_OR;
            3'd7: a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    assign w_op = in_instr[6:0];
    assign w_f3 = in_instr[14:12];
    assign w_f7 = in_instr[31:25];

    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b1;
        w_dec.pc  = in_pc;
        w_dec.rd  = in_instr[11:7];
        w_dec.rs1 = in_instr[19:15];
        w_dec.rs2 = in_instr[24:20];
        case (w_op)
            7'b0110111: begin
                w_dec.imm_ctrl = 3'd3; w_dec.alu_control = ALU_PASSB;
                w_dec.alu_src = 1'b1; w_dec.result_src = 2'd3; w_dec.reg_write = 1'b1;
            end
            7'b0010111: begin
                w_dec.imm_ctrl = 3'd3; w_dec.alu_src = 1'b1; w_dec.reg_write = 1'b1;
            end
            7'b1101111: begin
                w_dec.imm_ctrl = 3'd4; w_dec.jump = 1'b1;
                w_dec.result_src = 2'd2; w_dec.reg_write = 1'b1;
            end
            7'b1100111: begin
                w_dec.jump = 1'b1; w_dec.pc_target_src = 1'b1; w_dec.alu_src = 1'b1;
                w_dec.result_src = 2'd2; w_dec.reg_write = 1'b1;
                w_legal = (w_f3 == 3'd0);
            end
            7'b1100011: begin
                w_dec.imm_ctrl = 3'd2; w_dec.alu_control = ALU_SUB;
                w_dec.is_branch = 1'b1; w_dec.branch_type = w_f3;
                w_legal = (w_f3 != 3'd2) && (w_f3 != 3'd3);
            end
            7'b0000011: begin
                w_dec.alu_src = 1'b1; w_dec.result_src = 2'd1; w_dec.reg_write = 1'b1;
                w_dec.mem_width = w_f3;
                w_legal = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
            end
            7'b0100011: begin
                w_dec.imm_ctrl = 3'd1; w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1;
                w_dec.mem_width = w_f3;
                w_legal = (w_f3 <= 3'd2);
            end
            7'b0010011: begin
                w_dec.alu_src = 1'b1; w_dec.reg_write = 1'b1;
                w_dec.alu_control = alu_of(w_f3, 1'b0);
                if (w_f3 == 3'd1 && w_f7 != 7'b0000000) w_legal = 1'b0;
                if (w_f3 == 3'd5) begin
                    if (w_f7 == 7'b0100000) w_dec.alu_control = ALU_SRA;
                    else if (w_f7 != 7'b0000000) w_legal = 1'b0;
                end
            end
            7'b0110011: begin
                w_dec.reg_write = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_dec.alu_control = alu_of(w_f3, 1'b0);
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
                    w_dec.alu_control = alu_of(w_f3, 1'b1);
                end else if (w_f7 == 7'b0000001) begin
`ifdef DECODE_STAGE_RV32M_EN
                    w_dec.alu_control = {2'b10, w_f3};
`else
                    w_legal = 1'b0;
`endif
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
        case (w_dec.imm_ctrl)
            3'd1:    w_dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'd2:    w_dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
            3'd3:    w_dec.imm = {in_instr[31:12], 12'b0};
            3'd4:    w_dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
            default: w_dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        endcase
        // Illegal entries still flow downstream so execute can raise the trap in order.
        if (!w_legal) begin
            w_dec.illegal   = 1'b1;
            w_dec.reg_write = 1'b0;
            w_dec.mem_write = 1'b0;
        end
    end

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_dec;
                r_tail <= (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);
            end
            if (w_pop) r_head <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
            if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    assign out_pc            = r_mem[r_head].pc;
    assign out_rd            = r_mem[r_head].rd;
    assign out_rs1           = r_mem[r_head].rs1;
    assign out_rs2           = r_mem[r_head].rs2;
    assign out_imm           = r_mem[r_head].imm;
    assign result_src        = r_mem[r_head].result_src;
    assign mem_write         = r_mem[r_head].mem_write;
    assign mem_width         = r_mem[r_head].mem_width;
    assign alu_control       = r_mem[r_head].alu_control;
    assign alu_src           = r_mem[r_head].alu_src;
    assign immediate_control = r_mem[r_head].imm_ctrl;
    assign branch_type       = r_mem[r_head].branch_type;
    assign is_branch         = r_mem[r_head].is_branch;
    assign jump              = r_mem[r_head].jump;
    assign pc_target_src     = r_mem[r_head].pc_target_src;
    assign reg_write         = r_mem[r_head].reg_write;
    assign illegal           = r_mem[r_head].illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]     in_instr, out_imm;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [4:0]      out_rd, out_rs1, out_rs2, alu_control;
    logic [1:0]      result_src;
    logic [2:0]      mem_width, immediate_control, branch_type;
    logic            mem_write, alu_src, is_branch, jump, pc_target_src, reg_write, illegal;

    int n_pass  = 0;
    int n_total = 0;

    decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .result_src(result_src), .mem_write(mem_write), .mem_width(mem_width),
        .alu_control(alu_control), .alu_src(alu_src), .immediate_control(immediate_control),
        .branch_type(branch_type), .is_branch(is_branch), .jump(jump),
        .pc_target_src(pc_target_src), .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = '0;
        tick(); tick();
        reset = 1'b1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        check("rst_out_pc",    out_pc, 32'd0);
        check("rst_out_imm",   out_imm, 32'd0);
        check("rst_payload",   {out_rd, out_rs1, alu_control, reg_write, illegal, mem_write}, 32'd0);

        // addi x1,x2,5
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00510093; in_pc = 32'h100;
        tick();
        check("addi_valid",  {31'b0, out_valid}, 32'd1);
        check("addi_pc",     out_pc, 32'h100);
        check("addi_rd",     {27'b0, out_rd}, 32'd1);
        check("addi_rs1",    {27'b0, out_rs1}, 32'd2);
        check("addi_imm",    out_imm, 32'd5);
        check("addi_ctl",    {alu_control, alu_src, reg_write, illegal, result_src}, {5'd0, 1'b1, 1'b1, 1'b0, 2'd0});

        // sw x5,8(x2) pushed while addi pops
        in_instr = 32'h00512423; in_pc = 32'h104;
        tick();
        check("sw_pc",       out_pc, 32'h104);
        check("sw_imm",      out_imm, 32'd8);
        check("sw_rs",       {out_rs1, out_rs2}, {5'd2, 5'd5});
        check("sw_ctl",      {mem_write, mem_width, immediate_control, reg_write}, {1'b1, 3'd2, 3'd1, 1'b0});

        // lui x5,0x12345
        in_instr = 32'h123452B7; in_pc = 32'h108;
        tick();
        check("lui_imm",     out_imm, 32'h12345000);
        check("lui_ctl",     {alu_control, result_src, immediate_control, reg_write}, {5'd10, 2'd3, 3'd3, 1'b1});

        // bne x1,x2,-4
        in_instr = 32'hFE209EE3; in_pc = 32'h10C;
        tick();
        check("bne_imm",     out_imm, 32'hFFFFFFFC);
        check("bne_ctl",     {is_branch, branch_type, immediate_control, reg_write, illegal}, {1'b1, 3'd1, 3'd2, 1'b0, 1'b0});

        // addi x1,x0,-1
        in_instr = 32'hFFF00093; in_pc = 32'h110;
        tick();
        check("neg_imm",     out_imm, 32'hFFFFFFFF);

        // mul x3,x1,x2
        in_instr = 32'h022081B3; in_pc = 32'h114;
        tick();
`ifdef DECODE_STAGE_RV32M_EN
        check("mul_ctl",     {alu_control, illegal, reg_write}, {5'd16, 1'b0, 1'b1});
`else
        check("mul_ctl",     {illegal, reg_write, mem_write}, {1'b1, 1'b0, 1'b0});
`endif

        in_valid = 1'b0;
        tick();
        check("drain_empty", {31'b0, out_valid}, 32'd0);

        // fill to DEPTH with out_ready low, then offer one more
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00510093;
        for (int k = 0; k < DEPTH; k++) begin
            in_pc = 32'h200 + 32'(4 * k);
            tick();
            check("fill_in_ready", {31'b0, in_ready}, (k < DEPTH - 1) ? 32'd1 : 32'd0);
        end
        in_pc = 32'h200 + 32'(4 * DEPTH);
        tick();
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_hold_pc",  out_pc, 32'h200);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_pc", out_pc, 32'h200 + 32'(4 * k));
            tick();
        end
        check("drain_done", {31'b0, out_valid}, 32'd0);

        // flush with full buffer and valid input
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h300; tick();
        in_pc = 32'h304; tick();
        in_pc = 32'h308; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_ready", {31'b0, in_ready}, 32'd1);

        // flush while in_ready is high: the input must be dropped
        in_valid = 1'b1; in_pc = 32'h400; tick();
        in_pc = 32'h404; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_drop", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1; in_pc = 32'h500; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_flush_pc", out_pc, 32'h500);

        // reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h600; tick();
        in_valid = 1'b0; reset = 1'b0; tick();
        reset = 1'b1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_pc",    out_pc, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
